// File: rtl/video_init_seq.sv
// -----------------------------------------------------------------------------
// video_init_seq
//
// Board bring-up sequencer for the video decoder and encoder. After reset it
// drives a timed hardware-reset pulse on both devices (high / low / high), then
// launches an external register-configuration engine twice, first for the
// decoder and then for the encoder, using a start/done handshake. A NACK or a
// missing response restarts the whole sequence until the retry budget is
// exhausted. The result is reported to the video datapath as ready or fail.
//
// Ports:
//   clk        in   system clock
//   rst_in     in   synchronous, active-high reset
//   restart    in   single-cycle rerun request, honoured only in READY or FAIL
//   dec_rst_n  out  decoder hardware reset, active low
//   enc_rst_n  out  encoder hardware reset, active low
//   cfg_start  out  one-cycle launch pulse for the configuration engine
//   cfg_sel    out  configuration target (0 = decoder, 1 = encoder)
//   cfg_done   in   one-cycle pulse: configuration finished
//   cfg_err    in   one-cycle pulse: configuration failed
//   ready      out  high while in READY
//   fail       out  high while in FAIL
//   retry_cnt  out  retries consumed in the current run
//   state      out  current state encoding, for debug
// -----------------------------------------------------------------------------
module video_init_seq #(
  parameter int unsigned T_PRE       = 295000,
  parameter int unsigned T_RST       = 295000,
  parameter int unsigned T_POST      = 295000,
  parameter int unsigned CFG_TIMEOUT = 5900000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic       restart,
  output logic       dec_rst_n,
  output logic       enc_rst_n,
  output logic       cfg_start,
  output logic       cfg_sel,
  input  logic       cfg_done,
  input  logic       cfg_err,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRE     = 3'd1,
    S_RST     = 3'd2,
    S_POST    = 3'd3,
    S_CFG_DEC = 3'd4,
    S_CFG_ENC = 3'd5,
    S_READY   = 3'd6,
    S_FAIL    = 3'd7
  } state_t;

  // Timer value on the last cycle of each timed phase (timer is 0 on entry).
  localparam logic [31:0] PRE_LAST  = T_PRE - 32'd1;
  localparam logic [31:0] RST_LAST  = T_RST - 32'd1;
  localparam logic [31:0] POST_LAST = T_POST - 32'd1;
  // In the configuration states timer 0 is the launch cycle, so timer N is
  // the N-th wait cycle; the attempt expires after CFG_TIMEOUT of them.
  localparam logic [31:0] TIMEOUT_LAST = CFG_TIMEOUT;
  localparam logic [1:0]  RETRY_LIMIT  = 2'(MAX_RETRY);

  state_t      state_r;
  logic [31:0] timer_r;
  logic [1:0]  retry_cnt_r;
  logic        dec_rst_n_r;
  logic        enc_rst_n_r;
  logic        cfg_start_r;
  logic        cfg_sel_r;
  logic        ready_r;
  logic        fail_r;

  logic        listen_s;
  logic        attempt_fail_s;
  logic        attempt_ok_s;
  logic        retry_left_s;

  // Qualify engine responses: only in a configuration state and never in the
  // launch cycle; an error beats a simultaneous done.
  always_comb begin
    listen_s       = 1'b0;
    attempt_fail_s = 1'b0;
    attempt_ok_s   = 1'b0;
    retry_left_s   = 1'b0;
    if (((state_r == S_CFG_DEC) || (state_r == S_CFG_ENC)) && (timer_r != 32'd0)) begin
      listen_s = 1'b1;
    end else begin
      listen_s = 1'b0;
    end
    attempt_fail_s = listen_s & (cfg_err | (~cfg_done & (timer_r == TIMEOUT_LAST)));
    attempt_ok_s   = listen_s & cfg_done & ~cfg_err;
    retry_left_s   = (retry_cnt_r < RETRY_LIMIT);
  end

  // Sequencer FSM: state, phase timer, retry accounting and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_r     <= S_IDLE;
      timer_r     <= 32'd0;
      retry_cnt_r <= 2'd0;
      dec_rst_n_r <= 1'b1;
      enc_rst_n_r <= 1'b1;
      cfg_start_r <= 1'b0;
      cfg_sel_r   <= 1'b0;
      ready_r     <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_PRE;
          timer_r <= 32'd0;
        end

        S_PRE: begin
          if (timer_r == PRE_LAST) begin
            state_r     <= S_RST;
            timer_r     <= 32'd0;
            dec_rst_n_r <= 1'b0;
            enc_rst_n_r <= 1'b0;
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end

        S_RST: begin
          if (timer_r == RST_LAST) begin
            state_r     <= S_POST;
            timer_r     <= 32'd0;
            dec_rst_n_r <= 1'b1;
            enc_rst_n_r <= 1'b1;
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end

        S_POST: begin
          if (timer_r == POST_LAST) begin
            state_r     <= S_CFG_DEC;
            timer_r     <= 32'd0;
            cfg_start_r <= 1'b1;
            cfg_sel_r   <= 1'b0;
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end

        S_CFG_DEC, S_CFG_ENC: begin
          // Launch pulse lasts only the entry cycle.
          cfg_start_r <= 1'b0;
          if (attempt_fail_s) begin
            timer_r <= 32'd0;
            if (retry_left_s) begin
              // Every retry repeats the full reset pulse, not just the config.
              retry_cnt_r <= retry_cnt_r + 2'd1;
              state_r     <= S_PRE;
            end else begin
              state_r <= S_FAIL;
              fail_r  <= 1'b1;
            end
          end else if (attempt_ok_s) begin
            timer_r <= 32'd0;
            if (state_r == S_CFG_DEC) begin
              state_r     <= S_CFG_ENC;
              cfg_start_r <= 1'b1;
              cfg_sel_r   <= 1'b1;
            end else begin
              state_r <= S_READY;
              ready_r <= 1'b1;
            end
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end

        S_READY, S_FAIL: begin
          // Terminal states; late engine pulses are irrelevant here.
          if (restart) begin
            state_r     <= S_PRE;
            timer_r     <= 32'd0;
            retry_cnt_r <= 2'd0;
            ready_r     <= 1'b0;
            fail_r      <= 1'b0;
          end else begin
            timer_r <= 32'd0;
          end
        end

        default: begin
          state_r     <= S_IDLE;
          timer_r     <= 32'd0;
          retry_cnt_r <= 2'd0;
          dec_rst_n_r <= 1'b1;
          enc_rst_n_r <= 1'b1;
          cfg_start_r <= 1'b0;
          cfg_sel_r   <= 1'b0;
          ready_r     <= 1'b0;
          fail_r      <= 1'b0;
        end
      endcase
    end
  end

  assign dec_rst_n = dec_rst_n_r;
  assign enc_rst_n = enc_rst_n_r;
  assign cfg_start = cfg_start_r;
  assign cfg_sel   = cfg_sel_r;
  assign ready     = ready_r;
  assign fail      = fail_r;
  assign retry_cnt = retry_cnt_r;
  assign state     = state_r;

endmodule
